// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: funct3 encodings, the load tracker
// entry, and the decode helpers used by both request paths.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // Tracker tag field is sized for the widest tag any core configuration uses.
  localparam int MAX_TAG_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [2:0]           funct3;
    logic [1:0]           lane;
    logic                 err;
  } ld_track_t;

  function automatic logic ld_bad(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_LB, F3_LBU: ld_bad = 1'b0;
      F3_LH, F3_LHU: ld_bad = lane[0];
      F3_LW:         ld_bad = (lane != 2'b00);
      default:       ld_bad = 1'b1;
    endcase
  endfunction

  function automatic logic st_bad(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_SB:   st_bad = 1'b0;
      F3_SH:   st_bad = lane[0];
      F3_SW:   st_bad = (lane != 2'b00);
      default: st_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] st_mask(input logic [2:0] f3);
    case (f3)
      F3_SB:   st_mask = 4'b0001;
      F3_SH:   st_mask = 4'b0011;
      default: st_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a BRAM word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {lane_i, 3'b000};
    case (funct3_i)
      F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data_o = {24'b0, shifted[7:0]};
      F3_LHU:  data_o = {16'b0, shifted[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one BRAM port between loads and committed stores; stores win unless a load
// has waited MAX_WAIT cycles. Loads are tracked through the read latency and returned tagged.
module dmem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int TAG_W        = 4,
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT     = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              ld_valid_in,
  output logic              ld_ready_out,
  input  logic [31:0]       ld_addr_in,
  input  logic [2:0]        ld_funct3_in,
  input  logic [TAG_W-1:0]  ld_tag_in,
  input  logic              st_valid_in,
  output logic              st_ready_out,
  input  logic [31:0]       st_addr_in,
  input  logic [2:0]        st_funct3_in,
  input  logic [31:0]       st_data_in,
  input  logic              flush_in,
  output logic              ldr_valid_out,
  output logic [TAG_W-1:0]  ldr_tag_out,
  output logic [31:0]       ldr_data_out,
  output logic              ldr_err_out,
  output logic              st_err_out,
  output logic              mem_en_out,
  output logic [3:0]        mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [31:0]       mem_wdata_out,
  input  logic [31:0]       mem_rdata_in
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic              ld_win, ld_grant, st_grant;
  logic              ld_err, st_err;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              st_err_q, st_err_d;

  ld_track_t         trk_q [0:READ_LATENCY];
  ld_track_t         trk_d [0:READ_LATENCY];

  logic              ldr_valid_q, ldr_valid_d;
  logic [TAG_W-1:0]  ldr_tag_q, ldr_tag_d;
  logic [31:0]       ldr_data_q, ldr_data_d;
  logic              ldr_err_q, ldr_err_d;
  logic [31:0]       aligned;
  logic              unused_bits;

  assign unused_bits = ^{ld_addr_in[31:ADDR_W+2], st_addr_in[31:ADDR_W+2],
                         trk_q[READ_LATENCY].tag};

  load_align u_align (
    .funct3_i (trk_q[READ_LATENCY].funct3),
    .lane_i   (trk_q[READ_LATENCY].lane),
    .word_i   (mem_rdata_in),
    .data_o   (aligned)
  );

  always_comb begin
    // A flushed load still "wins" so the store cannot use that slot to starve it further.
    ld_win   = ld_valid_in && (!st_valid_in || (wait_q == WAIT_MAX));
    ld_grant = ld_win && !flush_in;
    st_grant = st_valid_in && !ld_win;
    ld_err   = ld_bad(ld_funct3_in, ld_addr_in[1:0]);
    st_err   = st_bad(st_funct3_in, st_addr_in[1:0]);

    wait_d = wait_q;
    if (!ld_valid_in || ld_grant) wait_d = '0;
    else if (wait_q != WAIT_MAX)  wait_d = wait_q + 1'b1;

    mem_en_d    = (st_grant && !st_err) || (ld_grant && !ld_err);
    mem_we_d    = (st_grant && !st_err) ? (st_mask(st_funct3_in) << st_addr_in[1:0]) : 4'b0000;
    mem_addr_d  = st_grant ? st_addr_in[ADDR_W+1:2] : ld_addr_in[ADDR_W+1:2];
    mem_wdata_d = st_grant ? (st_data_in << {st_addr_in[1:0], 3'b000}) : 32'b0;
    st_err_d    = st_grant && st_err;

    trk_d[0].valid  = ld_grant;
    trk_d[0].tag    = MAX_TAG_W'(ld_tag_in);
    trk_d[0].funct3 = ld_funct3_in;
    trk_d[0].lane   = ld_addr_in[1:0];
    trk_d[0].err    = ld_err;
    for (int k = 1; k <= READ_LATENCY; k++) trk_d[k] = trk_q[k-1];
    if (flush_in) begin
      for (int k = 0; k <= READ_LATENCY; k++) trk_d[k].valid = 1'b0;
    end

    // The oldest entry lines up with mem_rdata_in; a flush also kills it here.
    ldr_valid_d = trk_q[READ_LATENCY].valid && !flush_in;
    ldr_err_d   = ldr_valid_d && trk_q[READ_LATENCY].err;
    ldr_tag_d   = ldr_valid_d ? trk_q[READ_LATENCY].tag[TAG_W-1:0] : '0;
    ldr_data_d  = (ldr_valid_d && !trk_q[READ_LATENCY].err) ? aligned : 32'b0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wait_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'b0;
      st_err_q    <= 1'b0;
      for (int k = 0; k <= READ_LATENCY; k++) trk_q[k] <= '0;
      ldr_valid_q <= 1'b0;
      ldr_tag_q   <= '0;
      ldr_data_q  <= 32'b0;
      ldr_err_q   <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      st_err_q    <= st_err_d;
      for (int k = 0; k <= READ_LATENCY; k++) trk_q[k] <= trk_d[k];
      ldr_valid_q <= ldr_valid_d;
      ldr_tag_q   <= ldr_tag_d;
      ldr_data_q  <= ldr_data_d;
      ldr_err_q   <= ldr_err_d;
    end
  end

  assign ld_ready_out  = ld_grant;
  assign st_ready_out  = st_grant;
  assign mem_en_out    = mem_en_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;
  assign st_err_out    = st_err_q;
  assign ldr_valid_out = ldr_valid_q;
  assign ldr_tag_out   = ldr_tag_q;
  assign ldr_data_out  = ldr_data_q;
  assign ldr_err_out   = ldr_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a BRAM model and a result scoreboard.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_f3;
  logic [3:0]  ld_tag;
  logic        st_valid, st_ready;
  logic [31:0] st_addr;
  logic [2:0]  st_f3;
  logic [31:0] st_data;
  logic        flush;
  logic        ldr_valid;
  logic [3:0]  ldr_tag;
  logic [31:0] ldr_data;
  logic        ldr_err, st_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  dmem_port_arbiter #(.ADDR_W(12), .TAG_W(4), .READ_LATENCY(2), .MAX_WAIT(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .ld_valid_in(ld_valid), .ld_ready_out(ld_ready), .ld_addr_in(ld_addr),
    .ld_funct3_in(ld_f3), .ld_tag_in(ld_tag),
    .st_valid_in(st_valid), .st_ready_out(st_ready), .st_addr_in(st_addr),
    .st_funct3_in(st_f3), .st_data_in(st_data),
    .flush_in(flush),
    .ldr_valid_out(ldr_valid), .ldr_tag_out(ldr_tag), .ldr_data_out(ldr_data),
    .ldr_err_out(ldr_err), .st_err_out(st_err),
    .mem_en_out(mem_en), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
    .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata)
  );

  always #5 clk = ~clk;

  // BRAM model, two-cycle read latency
  logic [31:0] bram [0:4095];
  logic [31:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      rd_p1 <= bram[mem_addr];
    end
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t ldq[$];
  int   stq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  int   ldr_cnt = 0;
  exp_t mon_e;
  int   mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents a result or store error
  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (ldr_valid) begin
      ldr_cnt++;
      checks++;
      if (ldq.size() == 0) begin
        errors++;
        $display("FAIL ldr_unexpected cyc=%0d got tag=%0d data=%h err=%0d required no result",
                 cyc, ldr_tag, ldr_data, ldr_err);
      end else begin
        mon_e = ldq.pop_front();
        if (ldr_tag !== mon_e.tag || ldr_data !== mon_e.data || ldr_err !== mon_e.err ||
            cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL ldr_result got cyc=%0d tag=%0d data=%h err=%0d required cyc=%0d tag=%0d data=%h err=%0d",
                   cyc, ldr_tag, ldr_data, ldr_err, mon_e.cyc, mon_e.tag, mon_e.data, mon_e.err);
        end
      end
    end
    if (st_err) begin
      checks++;
      if (stq.size() == 0) begin
        errors++;
        $display("FAIL st_err_unexpected cyc=%0d got 1 required 0", cyc);
      end else begin
        mon_c = stq.pop_front();
        if (cyc != mon_c) begin
          errors++;
          $display("FAIL st_err_timing got cyc=%0d required cyc=%0d", cyc, mon_c);
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [3:0] tag,
                         input logic [31:0] d, input logic e, input bit expect_res);
    exp_t x;
    int   n = 0;
    bit   ok = 0;
    ld_valid = 1'b1; ld_addr = a; ld_f3 = f3; ld_tag = tag;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (ld_ready) begin
        ok = 1;
        if (expect_res) begin
          x.tag = tag; x.data = d; x.err = e; x.cyc = cyc + 4;
          ldq.push_back(x);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    ld_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ld_handshake got no grant required grant within 20 cycles");
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                          input bit exp_err);
    int n = 0;
    bit ok = 0;
    st_valid = 1'b1; st_addr = a; st_f3 = f3; st_data = d;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (st_ready) begin
        ok = 1;
        if (exp_err) stq.push_back(cyc + 1);
      end
      @(posedge clk); #1;
      n++;
    end
    st_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL st_handshake got no grant required grant within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int snap;
  logic [83:0] outs;

  initial begin
    rst_n = 1'b0; ld_valid = 0; ld_addr = 0; ld_f3 = 0; ld_tag = 0;
    st_valid = 0; st_addr = 0; st_f3 = 0; st_data = 0; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {ld_ready, st_ready, ldr_valid, ldr_tag, ldr_data, ldr_err, st_err,
            mem_en, mem_we, mem_addr, mem_wdata[5:0]};
    checks++;
    if (outs !== '0 || mem_wdata !== 32'b0) begin
      errors++;
      $display("FAIL reset_state got %h required 0", outs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Word store then immediate load of the same word
    do_store(32'h10, 3'd2, 32'hDEADBEEF, 0);
    do_load(32'h10, 3'd2, 4'd3, 32'hDEADBEEF, 0, 1);

    // Sub-word loads and a byte store
    do_load(32'h13, 3'd0, 4'd1, 32'hFFFFFFDE, 0, 1);
    do_load(32'h13, 3'd4, 4'd2, 32'h000000DE, 0, 1);
    do_load(32'h12, 3'd1, 4'd4, 32'hFFFFDEAD, 0, 1);
    do_load(32'h12, 3'd5, 4'd5, 32'h0000DEAD, 0, 1);
    do_store(32'h11, 3'd0, 32'h0000007F, 0);
    do_load(32'h10, 3'd2, 4'd6, 32'hDEAD7FEF, 0, 1);

    // Misaligned loads must not touch the BRAM
    do_store(32'h04, 3'd2, 32'h12345678, 0);
    idle(4);
    snap = en_cnt;
    do_load(32'h12, 3'd2, 4'd7, 32'h0, 1, 1);
    do_load(32'h13, 3'd1, 4'd8, 32'h0, 1, 1);
    do_load(32'h13, 3'd3, 4'd9, 32'h0, 1, 1);
    idle(4);
    checks++;
    if (en_cnt != snap) begin
      errors++;
      $display("FAIL err_load_mem_en got %0d enables required 0", en_cnt - snap);
    end
    do_store(32'h06, 3'd2, 32'hFFFFFFFF, 1);
    do_load(32'h04, 3'd2, 4'd10, 32'h12345678, 0, 1);
    idle(6);

    // Contention: loads get one grant every MAX_WAIT+1 cycles
    ld_valid = 1; ld_addr = 32'h40; ld_f3 = 3'd2; ld_tag = 4'd11;
    st_valid = 1; st_addr = 32'h40; st_f3 = 3'd2; st_data = 32'hCAFEF00D;
    for (int i = 0; i < 20; i++) begin
      exp_t x;
      @(negedge clk);
      checks++;
      if (ld_ready !== (i % 5 == 4) || st_ready !== (i % 5 != 4)) begin
        errors++;
        $display("FAIL starvation_grant i=%0d got ld=%0d st=%0d required ld=%0d st=%0d",
                 i, ld_ready, st_ready, (i % 5 == 4), (i % 5 != 4));
      end
      if (i % 5 == 4) begin
        x.tag = 4'd11; x.data = 32'hCAFEF00D; x.err = 0; x.cyc = cyc + 4;
        ldq.push_back(x);
      end
    end
    @(posedge clk); #1;
    ld_valid = 0; st_valid = 0;
    idle(8);

    // Flush after three back-to-back loads
    snap = ldr_cnt;
    do_load(32'h10, 3'd2, 4'd12, 32'h0, 0, 0);
    do_load(32'h14, 3'd2, 4'd13, 32'h0, 0, 0);
    do_load(32'h40, 3'd2, 4'd14, 32'h0, 0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(8);
    checks++;
    if (ldr_cnt != snap) begin
      errors++;
      $display("FAIL flush_results got %0d pulses required 0", ldr_cnt - snap);
    end
    do_load(32'h40, 3'd2, 4'd15, 32'hCAFEF00D, 0, 1);
    idle(6);

    // Reset with two loads in flight
    snap = ldr_cnt;
    do_load(32'h10, 3'd2, 4'd1, 32'h0, 0, 0);
    do_load(32'h04, 3'd2, 4'd2, 32'h0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    outs = {ld_ready, st_ready, ldr_valid, ldr_tag, ldr_data, ldr_err, st_err,
            mem_en, mem_we, mem_addr, mem_wdata[5:0]};
    checks++;
    if (outs !== '0 || mem_wdata !== 32'b0) begin
      errors++;
      $display("FAIL reset_midflight got %h required 0", outs);
    end
    idle(8);
    checks++;
    if (ldr_cnt != snap) begin
      errors++;
      $display("FAIL reset_stale got %0d pulses required 0", ldr_cnt - snap);
    end

    for (int n = 0; n < 20 && (ldq.size() != 0 || stq.size() != 0); n++) @(posedge clk);
    checks++;
    if (ldq.size() != 0 || stq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d loads %0d store errors outstanding required 0",
               ldq.size(), stq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
